// File: rtl/plc_pkg.sv
// Shared types and parameter legality checks for the PLC scan sequencer.
package plc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_WAIT   = 3'd4,
        ST_FAULT  = 3'd5
    } plc_state_t;

    localparam int unsigned SAFE_OUT_DEFAULT = 0;
    localparam int unsigned MIN_SCAN_PERIOD  = 4;
    localparam int unsigned MIN_WDT_LIMIT    = 1;
    localparam int unsigned MAX_CNT_W        = 31;

    // Period and watchdog limits must fit in the counter width.
    function automatic bit scan_params_ok(input int unsigned cnt_w,
                                          input int unsigned scan_period,
                                          input int unsigned wdt_limit);
        longint unsigned span;
        if (cnt_w < 1 || cnt_w > MAX_CNT_W) return 1'b0;
        span = 64'd1 << cnt_w;
        return (scan_period >= MIN_SCAN_PERIOD) && (64'(scan_period) < span) &&
               (wdt_limit >= MIN_WDT_LIMIT) && (64'(wdt_limit) < span);
    endfunction

endpackage

// File: rtl/plc_wdt.sv
// Saturating up-counter with clear, load, enable and a terminal-count flag.
module plc_wdt
    import plc_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned TC = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         tc_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc_c = (cnt >= W'(TC));

endmodule

// File: rtl/plc_scan_ctrl.sv
// PLC scan-cycle sequencer: latch inputs, run the core under a watchdog,
// publish its output image, then pad the scan out to a fixed period.
module plc_scan_ctrl
    import plc_pkg::*;
#(
    parameter int unsigned    IN_W        = 8,
    parameter int unsigned    OUT_W       = 8,
    parameter int unsigned    CNT_W       = 16,
    parameter int unsigned    SCAN_PERIOD = 1000,
    parameter int unsigned    WDT_LIMIT   = 800,
    parameter logic [OUT_W-1:0] SAFE_OUT  = OUT_W'(SAFE_OUT_DEFAULT)
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run_in,
    input  logic             fault_clr_in,
    input  logic [IN_W-1:0]  plc_in,
    input  logic             cpu_done_in,
    input  logic [OUT_W-1:0] cpu_out_img_in,
    output logic             cpu_rst_out,
    output logic [IN_W-1:0]  in_img_out,
    output logic [OUT_W-1:0] plc_out,
    output logic [CNT_W-1:0] scan_cnt_out,
    output logic             fault_out,
    output logic             overrun_out
);

    localparam bit          PARAMS_OK = scan_params_ok(CNT_W, SCAN_PERIOD, WDT_LIMIT);
    localparam int unsigned PER_TC    = SCAN_PERIOD - 1;
    localparam int unsigned WDT_TC    = WDT_LIMIT - 1;

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("plc_scan_ctrl: SCAN_PERIOD/WDT_LIMIT illegal for CNT_W");
        end
    endgenerate

    plc_state_t state, state_nxt;
    logic per_load_c, per_en_c, per_tc_c;
    logic wdt_clr_c, wdt_en_c, wdt_tc_c;

    // Period timer: starts at 1 on leaving LATCH so LATCH-to-LATCH spans SCAN_PERIOD.
    plc_wdt #(.W(CNT_W), .TC(PER_TC)) u_period (
        .clk      (clk_in),
        .rst      (rst_in),
        .clr      (1'b0),
        .load     (per_load_c),
        .load_val (CNT_W'(1)),
        .en       (per_en_c),
        .tc_c     (per_tc_c)
    );

    plc_wdt #(.W(CNT_W), .TC(WDT_TC)) u_wdt (
        .clk      (clk_in),
        .rst      (rst_in),
        .clr      (wdt_clr_c),
        .load     (1'b0),
        .load_val ('0),
        .en       (wdt_en_c),
        .tc_c     (wdt_tc_c)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        per_load_c = 1'b0;
        per_en_c   = 1'b0;
        wdt_clr_c  = 1'b0;
        wdt_en_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_in) state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                per_load_c = 1'b1;
                wdt_clr_c  = 1'b1;
                state_nxt  = ST_EXEC;
            end
            ST_EXEC: begin
                per_en_c = 1'b1;
                wdt_en_c = 1'b1;
                // Completion takes priority over a same-cycle watchdog expiry.
                if (cpu_done_in)   state_nxt = ST_UPDATE;
                else if (wdt_tc_c) state_nxt = ST_FAULT;
            end
            ST_UPDATE: begin
                per_en_c  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                per_en_c = 1'b1;
                if (per_tc_c) state_nxt = run_in ? ST_LATCH : ST_IDLE;
            end
            ST_FAULT: begin
                if (fault_clr_in) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output registers; status flags track the upcoming state so they align with it.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cpu_rst_out  <= 1'b1;
            in_img_out   <= '0;
            plc_out      <= SAFE_OUT;
            scan_cnt_out <= '0;
            fault_out    <= 1'b0;
            overrun_out  <= 1'b0;
        end else begin
            cpu_rst_out <= (state_nxt != ST_EXEC);
            fault_out   <= (state_nxt == ST_FAULT);
            if (state == ST_LATCH) in_img_out <= plc_in;
            if (state == ST_UPDATE) begin
                plc_out      <= cpu_out_img_in;
                scan_cnt_out <= scan_cnt_out + CNT_W'(1);
                if (per_tc_c) overrun_out <= 1'b1;
            end else if (state_nxt == ST_FAULT) begin
                plc_out <= SAFE_OUT;
            end
        end
    end

endmodule

// File: tb/tb_plc_scan_ctrl.sv
// Self-checking bench for plc_scan_ctrl with SCAN_PERIOD=10, WDT_LIMIT=12, CNT_W=4.
module tb_plc_scan_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       run_in = 1'b0;
    logic       fault_clr_in = 1'b0;
    logic [7:0] plc_in = 8'h00;
    logic       cpu_done_in = 1'b0;
    logic [7:0] cpu_out_img_in = 8'h00;
    logic       cpu_rst_out;
    logic [7:0] in_img_out;
    logic [7:0] plc_out;
    logic [3:0] scan_cnt_out;
    logic       fault_out;
    logic       overrun_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       run;
        logic       done;
        logic [7:0] img;
        logic [7:0] pin;
        logic       exp_rst;
        logic [7:0] exp_in;
        logic [7:0] exp_plc;
        logic [3:0] exp_scan;
        logic       exp_fault;
        logic       exp_ovr;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    plc_scan_ctrl #(
        .IN_W(8), .OUT_W(8), .CNT_W(4),
        .SCAN_PERIOD(10), .WDT_LIMIT(12), .SAFE_OUT(8'h00)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .run_in         (run_in),
        .fault_clr_in   (fault_clr_in),
        .plc_in         (plc_in),
        .cpu_done_in    (cpu_done_in),
        .cpu_out_img_in (cpu_out_img_in),
        .cpu_rst_out    (cpu_rst_out),
        .in_img_out     (in_img_out),
        .plc_out        (plc_out),
        .scan_cnt_out   (scan_cnt_out),
        .fault_out      (fault_out),
        .overrun_out    (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        run_in = 1'b0;
        cpu_done_in = 1'b0;
        fault_clr_in = 1'b0;
        tick();
        rst_in = 1'b0;
    endtask

    // Advance until the core is released, at most max_cyc edges.
    task automatic wait_exec(input int max_cyc, output int n);
        n = 0;
        while (cpu_rst_out && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic add_row(input logic run, input logic done, input logic [7:0] img,
                           input logic [7:0] pin, input logic rst, input logic [7:0] ein,
                           input logic [7:0] eplc, input logic [3:0] escan);
        vec_t v;
        v.run = run; v.done = done; v.img = img; v.pin = pin;
        v.exp_rst = rst; v.exp_in = ein; v.exp_plc = eplc; v.exp_scan = escan;
        v.exp_fault = 1'b0; v.exp_ovr = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        int n;
        int early;
        vec_t e;

        // Normal scan, ignored done in WAIT, exact period, run drop mid-scan.
        add_row(1, 0, 8'h00, 8'hA5, 1, 8'h00, 8'h00, 0);
        add_row(1, 0, 8'h00, 8'hA5, 0, 8'hA5, 8'h00, 0);
        add_row(1, 0, 8'h00, 8'hA5, 0, 8'hA5, 8'h00, 0);
        add_row(1, 0, 8'h00, 8'hA5, 0, 8'hA5, 8'h00, 0);
        add_row(1, 1, 8'h3C, 8'hA5, 1, 8'hA5, 8'h00, 0);
        add_row(1, 0, 8'h3C, 8'hA5, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 0, 8'h3C, 8'hA5, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 1, 8'hFF, 8'hA5, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 0, 8'hFF, 8'hA5, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 0, 8'hFF, 8'hA5, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 0, 8'hFF, 8'h5A, 1, 8'hA5, 8'h3C, 1);
        add_row(1, 0, 8'hFF, 8'h5A, 0, 8'h5A, 8'h3C, 1);
        add_row(0, 1, 8'h77, 8'h5A, 1, 8'h5A, 8'h3C, 1);
        add_row(0, 0, 8'h77, 8'h5A, 1, 8'h5A, 8'h77, 2);
        for (int i = 0; i < 8; i++) add_row(0, 0, 8'h77, 8'h5A, 1, 8'h5A, 8'h77, 2);

        do_reset();
        chk("reset_cpu_rst", 32'(cpu_rst_out), 32'd1);
        chk("reset_plc_out", 32'(plc_out), 32'h00);
        chk("reset_scan_cnt", 32'(scan_cnt_out), 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            run_in = tbl[i].run;
            cpu_done_in = tbl[i].done;
            cpu_out_img_in = tbl[i].img;
            plc_in = tbl[i].pin;
            sb.push_back(tbl[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst_out), 32'(e.exp_rst));
            chk($sformatf("vec%0d_in_img", i), 32'(in_img_out), 32'(e.exp_in));
            chk($sformatf("vec%0d_plc_out", i), 32'(plc_out), 32'(e.exp_plc));
            chk($sformatf("vec%0d_scan_cnt", i), 32'(scan_cnt_out), 32'(e.exp_scan));
            chk($sformatf("vec%0d_fault", i), 32'(fault_out), 32'(e.exp_fault));
            chk($sformatf("vec%0d_overrun", i), 32'(overrun_out), 32'(e.exp_ovr));
        end
        cpu_done_in = 1'b0;

        // Asynchronous reset mid-EXEC, observed before any clock edge.
        run_in = 1'b1; plc_in = 8'h11;
        tick(); tick();
        chk("areset_pre_exec", 32'(cpu_rst_out), 32'd0);
        #3 rst_in = 1'b1;
        #1;
        chk("areset_cpu_rst", 32'(cpu_rst_out), 32'd1);
        chk("areset_plc_out", 32'(plc_out), 32'h00);
        chk("areset_scan_cnt", 32'(scan_cnt_out), 32'd0);
        chk("areset_in_img", 32'(in_img_out), 32'h00);
        run_in = 1'b0;
        tick();
        rst_in = 1'b0;
        tick(); tick();
        chk("areset_idle_hold", 32'(cpu_rst_out), 32'd1);

        // Watchdog expiry, FAULT hold, acknowledge.
        do_reset();
        run_in = 1'b1; plc_in = 8'hC1;
        tick(); tick();
        cpu_done_in = 1'b1; cpu_out_img_in = 8'h3C;
        tick();
        cpu_done_in = 1'b0;
        tick();
        chk("wdt_pre_plc", 32'(plc_out), 32'h3C);
        wait_exec(20, n);
        chk("wdt_exec_delay", 32'(n), 32'd8);
        for (int i = 0; i < 11; i++) tick();
        chk("wdt_exec11_rst", 32'(cpu_rst_out), 32'd0);
        chk("wdt_exec11_fault", 32'(fault_out), 32'd0);
        tick();
        chk("wdt_fault", 32'(fault_out), 32'd1);
        chk("wdt_cpu_rst", 32'(cpu_rst_out), 32'd1);
        chk("wdt_plc_safe", 32'(plc_out), 32'h00);
        chk("wdt_in_img_hold", 32'(in_img_out), 32'hC1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("wdt_hold%0d", i), 32'(fault_out), 32'd1);
        end
        fault_clr_in = 1'b1; run_in = 1'b0;
        tick();
        fault_clr_in = 1'b0;
        chk("wdt_clr_fault", 32'(fault_out), 32'd0);
        chk("wdt_clr_cpu_rst", 32'(cpu_rst_out), 32'd1);
        tick();
        chk("wdt_idle_fault", 32'(fault_out), 32'd0);

        // Done and watchdog expiry in the same cycle: done wins.
        do_reset();
        run_in = 1'b1; plc_in = 8'h44;
        tick(); tick();
        for (int i = 0; i < 11; i++) tick();
        cpu_done_in = 1'b1; cpu_out_img_in = 8'hC3;
        tick();
        cpu_done_in = 1'b0;
        chk("simul_fault", 32'(fault_out), 32'd0);
        chk("simul_cpu_rst", 32'(cpu_rst_out), 32'd1);
        tick();
        chk("simul_plc", 32'(plc_out), 32'hC3);
        chk("simul_scan", 32'(scan_cnt_out), 32'd1);
        chk("simul_fault2", 32'(fault_out), 32'd0);
        chk("simul_overrun", 32'(overrun_out), 32'd1);

        // Overrun: done on 10th EXEC cycle.
        do_reset();
        run_in = 1'b1; plc_in = 8'h21;
        tick(); tick();
        chk("ovr_initial", 32'(overrun_out), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        cpu_done_in = 1'b1; cpu_out_img_in = 8'h5A;
        tick();
        cpu_done_in = 1'b0;
        tick();
        chk("ovr_plc", 32'(plc_out), 32'h5A);
        chk("ovr_flag", 32'(overrun_out), 32'd1);
        tick();
        chk("ovr_latch_rst", 32'(cpu_rst_out), 32'd1);
        tick();
        chk("ovr_exec_rst", 32'(cpu_rst_out), 32'd0);
        cpu_done_in = 1'b1; cpu_out_img_in = 8'h66;
        tick();
        cpu_done_in = 1'b0;
        tick();
        chk("ovr_next_plc", 32'(plc_out), 32'h66);
        chk("ovr_sticky", 32'(overrun_out), 32'd1);
        chk("ovr_next_scan", 32'(scan_cnt_out), 32'd2);

        // Scan counter wrap, then run drop during EXEC.
        do_reset();
        run_in = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wait_exec(20, n);
            chk($sformatf("wrap%0d_exec", i), 32'(cpu_rst_out), 32'd0);
            cpu_done_in = 1'b1; cpu_out_img_in = 8'(i + 1);
            tick();
            cpu_done_in = 1'b0;
            tick();
            chk($sformatf("wrap%0d_scan", i), 32'(scan_cnt_out), 32'((i + 1) % 16));
        end
        wait_exec(20, n);
        chk("drop_exec", 32'(cpu_rst_out), 32'd0);
        run_in = 1'b0;
        tick(); tick();
        cpu_done_in = 1'b1; cpu_out_img_in = 8'h99;
        tick();
        cpu_done_in = 1'b0;
        tick();
        chk("drop_plc", 32'(plc_out), 32'h99);
        chk("drop_scan", 32'(scan_cnt_out), 32'd1);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (!cpu_rst_out) early++;
        end
        chk("drop_no_restart", 32'(early), 32'd0);
        chk("drop_idle_rst", 32'(cpu_rst_out), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
